// File: rtl/vector_mem_sequencer.sv
// Vector load/store sequencer for the MEM stage: one RAM element access per clock,
// with loads gathered into a shadow vector and published atomically on completion.
module vector_mem_sequencer #(
    parameter int ELEMENTS = 16,
    parameter int ELEM_W   = 16,
    parameter int ADDR_W   = 19,
    parameter int RAM_LAT  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_load,
    input  logic                         start_store,
    input  logic [ADDR_W-1:0]            base_addr,
    input  logic [ELEMENTS*ELEM_W-1:0]   store_vec,
    input  logic [4:0]                   rd_in,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [ELEM_W-1:0]            mem_wdata,
    output logic                         mem_wren,
    input  logic [ELEM_W-1:0]            mem_rdata,
    output logic                         busy,
    output logic                         done,
    output logic [ELEMENTS*ELEM_W-1:0]   vec_out,
    output logic [4:0]                   rd_out
);

    localparam int VEC_W = ELEMENTS * ELEM_W;
    localparam int CNT_W = $clog2(ELEMENTS + 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LD_ISSUE = 3'd1;
    localparam logic [2:0] LD_DRAIN = 3'd2;
    localparam logic [2:0] ST       = 3'd3;
    localparam logic [2:0] FIN      = 3'd4;

    logic [2:0]         state;
    logic [ADDR_W-1:0]  base_q;
    logic [VEC_W-1:0]   store_q;
    logic [VEC_W-1:0]   shadow;
    logic [VEC_W-1:0]   shadow_next;
    logic [4:0]         rd_q;
    logic [CNT_W-1:0]   issue_cnt;
    logic [CNT_W-1:0]   cap_cnt;
    logic [RAM_LAT-1:0] tag;
    logic               issuing;
    logic               capture;
    logic               last_issue;
    logic               last_cap;

    assign issuing    = (state == LD_ISSUE);
    assign capture    = tag[RAM_LAT-1];
    assign last_issue = (issue_cnt == CNT_W'(ELEMENTS - 1));
    assign last_cap   = capture && (cap_cnt == CNT_W'(ELEMENTS - 1));

    // Outputs decode from state so reset removes mem_wren without waiting for a clock.
    assign busy     = (state == LD_ISSUE) || (state == LD_DRAIN) || (state == ST);
    assign done     = (state == FIN);
    assign mem_wren = (state == ST);
    assign mem_addr = (state == ST || state == LD_ISSUE) ? base_q + ADDR_W'(issue_cnt) : '0;

    always_comb begin
        mem_wdata = '0;
        if (state == ST) begin
            for (int unsigned i = 0; i < ELEMENTS; i++) begin
                if (issue_cnt == CNT_W'(i)) mem_wdata = store_q[i*ELEM_W +: ELEM_W];
            end
        end
    end

    always_comb begin
        shadow_next = shadow;
        for (int unsigned i = 0; i < ELEMENTS; i++) begin
            if (capture && cap_cnt == CNT_W'(i)) shadow_next[i*ELEM_W +: ELEM_W] = mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            base_q    <= '0;
            store_q   <= '0;
            rd_q      <= '0;
            issue_cnt <= '0;
            cap_cnt   <= '0;
            tag       <= '0;
            shadow    <= '0;
            vec_out   <= '0;
            rd_out    <= '0;
        end else begin
            tag[0] <= issuing;
            for (int unsigned i = 1; i < RAM_LAT; i++) tag[i] <= tag[i-1];

            if (capture) begin
                shadow  <= shadow_next;
                cap_cnt <= cap_cnt + 1'b1;
            end
            // The final lane is merged directly so vec_out changes in one step on entry to FIN.
            if (last_cap) begin
                vec_out <= shadow_next;
                rd_out  <= rd_q;
            end

            case (state)
                IDLE: begin
                    issue_cnt <= '0;
                    cap_cnt   <= '0;
                    if (start_load) begin
                        base_q <= base_addr;
                        rd_q   <= rd_in;
                        state  <= LD_ISSUE;
                    end else if (start_store) begin
                        base_q  <= base_addr;
                        store_q <= store_vec;
                        state   <= ST;
                    end
                end
                ST: begin
                    issue_cnt <= issue_cnt + 1'b1;
                    if (last_issue) state <= FIN;
                end
                LD_ISSUE: begin
                    issue_cnt <= issue_cnt + 1'b1;
                    if (last_issue) state <= LD_DRAIN;
                end
                LD_DRAIN: begin
                    if (last_cap) state <= FIN;
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed bench for vector_mem_sequencer: stores, loads at RAM latency 1 and 3,
// address wrap, request arbitration, and asynchronous reset during a store.
module tb_vector_mem_sequencer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_load = 1'b0;
    logic         start_store = 1'b0;
    logic         start_load3 = 1'b0;
    logic         start_store3 = 1'b0;
    logic [18:0]  base_addr = '0;
    logic [255:0] store_vec = '0;
    logic [4:0]   rd_in = '0;

    logic [18:0]  mem_addr, mem_addr3;
    logic [15:0]  mem_wdata, mem_wdata3;
    logic         mem_wren, mem_wren3;
    logic [15:0]  mem_rdata, mem_rdata3, r1, r2;
    logic         busy, busy3, done, done3;
    logic [255:0] vec_out, vec_out3;
    logic [4:0]   rd_out, rd_out3;

    int checks = 0;
    int errors = 0;
    int wren_total = 0;

    always #5 clk = ~clk;

    vector_mem_sequencer #(.ELEMENTS(16), .ELEM_W(16), .ADDR_W(19), .RAM_LAT(1)) dut (
        .clk(clk), .rst(rst), .start_load(start_load), .start_store(start_store),
        .base_addr(base_addr), .store_vec(store_vec), .rd_in(rd_in),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
        .mem_rdata(mem_rdata), .busy(busy), .done(done),
        .vec_out(vec_out), .rd_out(rd_out)
    );

    vector_mem_sequencer #(.ELEMENTS(16), .ELEM_W(16), .ADDR_W(19), .RAM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start_load(start_load3), .start_store(start_store3),
        .base_addr(base_addr), .store_vec(store_vec), .rd_in(rd_in),
        .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_wren(mem_wren3),
        .mem_rdata(mem_rdata3), .busy(busy3), .done(done3),
        .vec_out(vec_out3), .rd_out(rd_out3)
    );

    // RAM models: mem[a] = a[15:0] ^ 0xA5A5, read latency 1 and 3
    always @(posedge clk) begin
        mem_rdata  <= mem_addr[15:0] ^ 16'hA5A5;
        r1         <= mem_addr3[15:0] ^ 16'hA5A5;
        r2         <= r1;
        mem_rdata3 <= r2;
    end

    always @(negedge clk) if (mem_wren === 1'b1) wren_total++;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] exp_vec(input logic [18:0] base);
        logic [255:0] v;
        logic [18:0]  a;
        v = '0;
        for (int i = 0; i < 16; i++) begin
            a = base + 19'(i);
            v[i*16 +: 16] = a[15:0] ^ 16'hA5A5;
        end
        return v;
    endfunction

    task automatic wait_done1(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_done3(output int cyc);
        cyc = 1;
        while (done3 !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int dn;
        int wr;
        logic [18:0] a;
        logic [255:0] sv;

        // ---- reset state ----
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_wren", mem_wren, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_done", done, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_vec", vec_out, 0);
        check("rst_rd", rd_out, 0);
        check("rst_busy3", busy3, 0);

        // ---- store: base 0x100, lanes 0x1000+i ----
        sv = '0;
        for (int i = 0; i < 16; i++) sv[i*16 +: 16] = 16'h1000 + 16'(i);
        base_addr = 19'h00100; store_vec = sv; start_store = 1'b1;
        check("st_idle_busy", busy, 0);
        @(negedge clk);
        start_store = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check("st_wren", mem_wren, 1);
            check("st_addr", mem_addr, 19'h100 + k);
            check("st_wdata", mem_wdata, 16'h1000 + k);
            check("st_busy", busy, 1);
            check("st_done_early", done, 0);
            @(negedge clk);
        end
        check("st_done17", done, 1);
        check("st_fin_busy", busy, 0);
        check("st_fin_wren", mem_wren, 0);
        @(negedge clk);
        check("st_done_pulse", done, 0);

        // ---- load, RAM_LAT=1: base 0x200, rd 5 ----
        base_addr = 19'h00200; rd_in = 5'd5; start_load = 1'b1;
        @(negedge clk);
        start_load = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check("ld_addr", mem_addr, 19'h200 + k);
            check("ld_wren", mem_wren, 0);
            check("ld_busy", busy, 1);
            check("ld_vec_hold", vec_out, 0);
            @(negedge clk);
        end
        check("ld_drain_busy", busy, 1);
        check("ld_drain_done", done, 0);
        check("ld_drain_vec", vec_out, 0);
        @(negedge clk);
        check("ld_done18", done, 1);
        check("ld_vec", vec_out, exp_vec(19'h00200));
        check("ld_rd", rd_out, 5);
        @(negedge clk);
        check("ld_done_pulse", done, 0);
        check("ld_vec_persist", vec_out, exp_vec(19'h00200));

        // ---- wrap: base 0x7FFFE ----
        base_addr = 19'h7FFFE; rd_in = 5'd9; start_load = 1'b1;
        @(negedge clk);
        start_load = 1'b0;
        for (int k = 0; k < 16; k++) begin
            a = 19'h7FFFE + 19'(k);
            check("wrap_addr", mem_addr, a);
            @(negedge clk);
        end
        @(negedge clk);
        check("wrap_done", done, 1);
        check("wrap_vec", vec_out, exp_vec(19'h7FFFE));
        check("wrap_rd", rd_out, 9);

        // ---- simultaneous requests, mid-op start, start during FIN ----
        @(negedge clk);
        base_addr = 19'h00300; rd_in = 5'd3; store_vec = '1;
        start_load = 1'b1; start_store = 1'b1;
        @(negedge clk);
        start_load = 1'b0; start_store = 1'b0;
        dn = 0; wr = 0;
        for (int c = 1; c <= 24; c++) begin
            if (done === 1'b1) dn++;
            if (mem_wren === 1'b1) wr++;
            start_load  = (c == 5);
            start_store = (c == 5) || (done === 1'b1);
            @(negedge clk);
        end
        start_load = 1'b0; start_store = 1'b0;
        check("both_one_done", dn, 1);
        check("both_no_wren", wr, 0);
        check("both_rd", rd_out, 3);
        check("both_vec", vec_out, exp_vec(19'h00300));
        check("both_idle", busy, 0);

        // ---- reset mid-store at k=7 ----
        base_addr = 19'h00400; store_vec = sv; start_store = 1'b1;
        @(negedge clk);
        start_store = 1'b0;
        for (int k = 0; k < 7; k++) @(negedge clk);
        check("rs_k7_wren", mem_wren, 1);
        check("rs_k7_addr", mem_addr, 19'h407);
        #1 rst = 1'b1;
        #1;
        check("rs_async_wren", mem_wren, 0);
        check("rs_async_busy", busy, 0);
        check("rs_async_addr", mem_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rs_post_busy", busy, 0);
        check("rs_post_done", done, 0);
        check("rs_post_vec", vec_out, 0);
        base_addr = 19'h00010; rd_in = 5'd1; start_load = 1'b1;
        @(negedge clk);
        start_load = 1'b0;
        wait_done1(cyc);
        check("rs_load_lat", cyc, 18);
        check("rs_load_vec", vec_out, exp_vec(19'h00010));
        check("rs_load_rd", rd_out, 1);
        check("wren_total", wren_total, 24);

        // ---- RAM_LAT=3 instance: base 0x500, rd 7 ----
        @(negedge clk);
        base_addr = 19'h00500; rd_in = 5'd7; start_load3 = 1'b1;
        @(negedge clk);
        start_load3 = 1'b0;
        check("l3_vec_hold", vec_out3, 0);
        wait_done3(cyc);
        check("l3_lat", cyc, 20);
        check("l3_vec", vec_out3, exp_vec(19'h00500));
        check("l3_rd", rd_out3, 7);
        check("l3_wren", mem_wren3, 0);
        @(negedge clk);
        check("l3_done_pulse", done3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_mem_sequencer.md
Name: vector_mem_sequencer

Overview:
- Sequences vector loads and stores between the 16-lane vector datapath and the 16-bit-wide data RAM in the MEM stage.
- Issues one element access per clock: 16 writes for a store, or 16 pipelined reads that are gathered into a 256-bit vector for a load.
- Asserts busy so the pipeline stalls; returns the gathered vector plus its destination register to the MEM/WB boundary.

Parameters:
- ELEMENTS, 16, vector lanes per access.
- ELEM_W, 16, bits per element and RAM data width.
- ADDR_W, 19, RAM address width.
- RAM_LAT, 1, RAM read latency in clocks (1..3), from mem_addr valid to mem_rdata valid.

Ports:
- clk  in  1  pipeline clock; all state is updated on its rising edge.
- rst  in  1  asynchronous reset, active-high.
- start_load  in  1  request a vector load; sampled only in IDLE.
- start_store  in  1  request a vector store; sampled only in IDLE.
- base_addr  in  ADDR_W  address of element 0; latched at start.
- store_vec  in  ELEMENTS*ELEM_W  store data; element i is in bits [16i+15:16i]; latched at start.
- rd_in  in  5  destination vector register for a load; latched at start.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  ELEM_W  RAM write data.
- mem_wren  out  1  RAM write enable.
- mem_rdata  in  ELEM_W  RAM read data.
- busy  out  1  stall request to the pipeline.
- done  out  1  one-cycle pulse when an operation completes.
- vec_out  out  ELEMENTS*ELEM_W  gathered load vector; holds its value until the next load completes.
- rd_out  out  5  destination register of the last completed load.

Behaviour:
- Reset (asynchronous, any state): state=IDLE. mem_addr, mem_wdata, vec_out and rd_out are 0. mem_wren, busy and done are 0. The issue counter and the capture counter are 0. An operation in progress is aborted, and no write is issued after rst is asserted.
- FSM states: IDLE, LD_ISSUE, LD_DRAIN, ST, FIN.
- IDLE:
  - start_load=1 -> latch base_addr and rd_in, go to LD_ISSUE.
  - else start_store=1 -> latch base_addr and store_vec, go to ST.
  - If both are asserted, the load wins and the store is dropped.
  - busy=0 in IDLE. busy goes to 1 in the cycle after the start edge.
- ST:
  - Cycle k (k=0..15) drives mem_addr=base+k, mem_wdata=element k and mem_wren=1.
  - After k=15, go to FIN.
  - A store occupies 16 cycles of busy; mem_wren is never asserted outside ST.
- LD_ISSUE:
  - Cycle k (k=0..15) drives mem_addr=base+k with mem_wren=0.
  - A RAM_LAT-deep valid shift register tags each issued read.
  - When a tag emerges, mem_rdata is written to vec_out lane c, and c increments.
  - After k=15, go to LD_DRAIN.
- LD_DRAIN: keep capturing until c reaches 16, then go to FIN. This state lasts RAM_LAT cycles.
- vec_out update: lanes are written into an internal shadow register. vec_out and rd_out update atomically on entry to FIN, so a partial vector is never visible.
- FIN: done=1 and busy=0 for one cycle, then go to IDLE. A start asserted in FIN is ignored; the next start is accepted in IDLE.
- Latency from the start edge to the done cycle: store = 17 cycles; load = 17 + RAM_LAT cycles.
- Address arithmetic: base+k is taken modulo 2^ADDR_W, so 0x7FFFF+1 wraps to 0x00000.
- Start requests while busy are ignored; requests are not queued.

Test Plan:
- Store: base=0x00100, store_vec lanes = 0x1000+i -> 16 consecutive cycles with mem_wren=1, addr 0x100..0x10F, wdata 0x1000..0x100F. done fires at cycle 17. mem_wren is never asserted at any other time.
- Load, RAM_LAT=1: RAM model with mem[a]=a[15:0]^0xA5A5, base=0x00200, rd_in=5 -> vec_out lane i = (0x200+i)^0xA5A5, rd_out=5, done at cycle 18. vec_out is unchanged before done.
- Wrap: load with base=0x7FFFE -> addresses 0x7FFFE, 0x7FFFF, 0x00000 .. 0x0000D.
- Simultaneous requests: start_load=1 and start_store=1 in the same cycle -> a load is performed and mem_wren stays 0 throughout. A start pulse mid-operation -> ignored, and exactly one done is produced.
- Reset mid-store: assert rst at k=7 -> mem_wren drops to 0 with no clock edge needed. After release: state IDLE, busy=0, and a subsequent load completes normally.
- Parameter sweep: RAM_LAT=3 -> load done at cycle 20 with correct lane alignment (no off-by-latency shift).
